// File: rtl/cad_ca1_pkg.sv
// cad_ca1_pkg: shared word/count sizes and drain-buffer state encoding
package cad_ca1_pkg;
  localparam int WORD_W = 32;
  localparam int NUM_COUNT = 26;
  localparam int CNT_BITS = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/word_ram.sv
// word_ram: DEPTH x WIDTH register file, ports clk/i_we/i_waddr/i_wdata sync write, i_raddr/o_rdata async read
module word_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 26,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/result_drain_buffer.sv
// result_drain_buffer: captures words on storeConvertedNumber, drains them on writeToFile over out_valid/out_ready with out_last/done/count/full/dropped status
module result_drain_buffer
  import cad_ca1_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = NUM_COUNT,
  parameter int CNT_W = CNT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             storeConvertedNumber,
  input  logic [WIDTH-1:0] convertedNumber,
  input  logic             writeToFile,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             dropped,
  output logic             done
);
  state_t r_state;
  logic [CNT_W-1:0] r_rd;
  logic [CNT_W-1:0] w_cnt_n;
  logic [CNT_W-1:0] w_raddr;
  logic [WIDTH-1:0] w_rdata;
  logic w_we;
  assign full = count == CNT_W'(DEPTH);
  assign w_we = storeConvertedNumber & (r_state == IDLE | r_state == FILL) & ~full;
  assign w_cnt_n = count + CNT_W'(w_we);
  assign w_raddr = r_state == DRAIN ? r_rd + 1'b1 : '0;
  word_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(CNT_W)) u_ram (
    .clk(clk),
    .i_we(w_we),
    .i_waddr(count),
    .i_wdata(convertedNumber),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_rd      <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      dropped   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (storeConvertedNumber & ~w_we) dropped <= 1'b1;
      if (w_we) count <= w_cnt_n;
      case (r_state)
        IDLE, FILL:
          if (writeToFile) begin
            if (w_cnt_n == '0) r_state <= DONE;
            else begin
              r_state   <= DRAIN;
              out_valid <= 1'b1;
              out_last  <= w_cnt_n == CNT_W'(1);
              out_data  <= count == '0 ? convertedNumber : w_rdata;
            end
          end else if (w_we) r_state <= FILL;
        DRAIN:
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              r_state   <= DONE;
            end else begin
              r_rd     <= r_rd + 1'b1;
              out_data <= w_rdata;
              out_last <= r_rd + CNT_W'(2) == count;
            end
          end
        default: begin
          done    <= 1'b1;
          count   <= '0;
          r_rd    <= '0;
          r_state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_result_drain_buffer.sv
// tb_result_drain_buffer: directed and randomized checks of result_drain_buffer against a queue model
module tb_result_drain_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic storeConvertedNumber = 1'b0;
  logic [31:0] convertedNumber = '0;
  logic writeToFile = 1'b0;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_last;
  logic [4:0] count;
  logic full;
  logic dropped;
  logic done;
  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  bit m_drop = 1'b0;
  result_drain_buffer dut (
    .clk(clk),
    .rst(rst),
    .storeConvertedNumber(storeConvertedNumber),
    .convertedNumber(convertedNumber),
    .writeToFile(writeToFile),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .count(count),
    .full(full),
    .dropped(dropped),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_store(input logic [31:0] w);
    if (q.size() < 26) q.push_back(w);
    else m_drop = 1'b1;
  endtask
  task automatic store(input logic [31:0] w);
    storeConvertedNumber = 1'b1;
    convertedNumber = w;
    model_store(w);
    step();
    storeConvertedNumber = 1'b0;
  endtask
  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_full"}, 32'(full), 32'(q.size() == 26));
    chk({tag, "_dropped"}, 32'(dropped), 32'(m_drop));
  endtask
  task automatic drain(input logic [31:0] pat, input bit with_st, input logic [31:0] w);
    int n, i, cyc;
    writeToFile = 1'b1;
    storeConvertedNumber = with_st;
    convertedNumber = w;
    if (with_st) model_store(w);
    step();
    writeToFile = 1'b0;
    storeConvertedNumber = 1'b0;
    n = q.size();
    i = 0;
    cyc = 0;
    while (i < n && cyc < 1000) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("data", out_data, q[i]);
      chk("last", 32'(out_last), 32'(i == n - 1));
      out_ready = cyc < 32 ? pat[cyc] : 1'b1;
      step();
      if (out_ready) i++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_beats", 32'(i), 32'(n));
    chk("valid_end", 32'(out_valid), 32'd0);
    chk("done_early", 32'(done), 32'd0);
    step();
    chk("done", 32'(done), 32'd1);
    chk("count_clr", 32'(count), 32'd0);
    chk("valid_in_done", 32'(out_valid), 32'd0);
    chk("dropped_kept", 32'(dropped), 32'(m_drop));
    step();
    chk("done_pulse", 32'(done), 32'd0);
    q.delete();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk_status("rst");
    rst = 1'b0;
    step();
    for (int k = 1; k <= 26; k++) store(32'(k));
    chk_status("fill26");
    drain(32'hFFFFFFFF, 1'b0, '0);
    for (int k = 0; k < 3; k++) store($urandom);
    chk_status("fill3");
    drain(32'hFFFFFFF9, 1'b0, '0);
    for (int k = 0; k < 26; k++) store($urandom);
    chk_status("full26");
    store($urandom);
    chk_status("over27");
    drain($urandom, 1'b0, '0);
    drain(32'hFFFFFFFF, 1'b0, '0);
    store($urandom);
    store($urandom);
    drain(32'hFFFFFFFF, 1'b1, $urandom);
    for (int k = 0; k < 5; k++) store($urandom);
    writeToFile = 1'b1;
    step();
    writeToFile = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("pre_rst_data", out_data, q[2]);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_dropped", 32'(dropped), 32'd0);
    out_ready = 1'b0;
    q.delete();
    m_drop = 1'b0;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) store($urandom);
    chk_status("post_rst");
    drain($urandom, 1'b0, '0);
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(0, 27);
      for (int k = 0; k < n; k++) store($urandom);
      chk_status("rand_fill");
      drain($urandom, 1'($urandom_range(0, 1)), $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
